// File: rtl/arbitro_registrador.sv
// Round-robin write sequencer for a shared falling-edge `registrador`.
// One requester at a time is granted. Its word is latched at grant and presented on reg_d.
// reg_en is driven for exactly one cycle, then the winner gets a one-cycle ack.
// The sequencer waits for the winner to drop its request before it arbitrates again.
module arbitro_registrador #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] data_in,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       ack,
    output logic                   reg_en,
    output logic [WIDTH-1:0]       reg_d,
    output logic                   busy,
    output logic [7:0]             wr_count
);

    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StAck,
        StRelease
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [IdxW-1:0]   win_q, win_d;
    logic [WIDTH-1:0]  hold_q, hold_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [7:0]        cnt_q, cnt_d;

    logic              arb_found;
    logic [IdxW-1:0]   arb_idx;
    logic [IdxW-1:0]   arb_ptr_next;
    logic [WIDTH-1:0]  arb_data;
    logic [31:0]       cand;
    logic [IdxW-1:0]   cand_idx;

    // Round-robin search: first active request scanning ptr, ptr+1, ... modulo N_REQ.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IdxW'(cand);
            if (!arb_found && req[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    // Pointer moves just past the winner so it goes to the back of the line.
    always_comb begin
        if (arb_idx == IdxW'(N_REQ - 1)) begin
            arb_ptr_next = '0;
        end else begin
            arb_ptr_next = arb_idx + 1'b1;
        end
    end

    // Data word of the current arbitration winner.
    always_comb begin
        arb_data = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (arb_idx == IdxW'(k)) begin
                arb_data = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state logic for the grant / load / ack / release sequence.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (arb_found) begin
                    state_d        = StLoad;
                    win_d          = arb_idx;
                    hold_d         = arb_data;
                    gnt_d          = '0;
                    gnt_d[arb_idx] = 1'b1;
                    ptr_d          = arb_ptr_next;
                end
            end
            StLoad: begin
                // The register has captured on the falling edge of this cycle.
                state_d = StAck;
                cnt_d   = cnt_q + 8'd1;
            end
            StAck: begin
                state_d = StRelease;
            end
            StRelease: begin
                // Only the winner's line matters here; other requests wait for IDLE.
                if (!req[win_q]) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    // Controller state; reset abandons any in-flight write without an ack.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            win_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode the registered state, giving the register half a cycle of setup.
    always_comb begin
        gnt      = gnt_q;
        ack      = (state_q == StAck) ? gnt_q : '0;
        reg_en   = (state_q == StLoad);
        busy     = (state_q != StIdle);
        reg_d    = (state_q != StIdle) ? hold_q : '0;
        wr_count = cnt_q;
    end

endmodule

// File: tb/tb_arbitro_registrador.sv
// Scoreboard bench for arbitro_registrador with a behavioural registrador model.
module tb_arbitro_registrador;

    logic        clk;
    logic        rstn;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        reg_en;
    logic [7:0]  reg_d;
    logic        busy;
    logic [7:0]  wr_count;
    logic [7:0]  q_reg;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t ack_q[$];
    exp_t mon_e;
    logic [7:0] cnt_model;

    int checks;
    int failures;
    int rr_cnt[4];
    int reraise[4];
    int pend[4];
    int drop_delay[4];
    int acks_seen;
    int cyc;
    int ack_cyc[$];
    int a0;

    arbitro_registrador #(
        .N_REQ (4),
        .WIDTH (8)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req),
        .data_in  (data_in),
        .gnt      (gnt),
        .ack      (ack),
        .reg_en   (reg_en),
        .reg_d    (reg_d),
        .busy     (busy),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared registrador: falling-edge capture with enable, async clear.
    always @(negedge clk or negedge rstn) begin
        if (!rstn) q_reg <= 8'h00;
        else if (reg_en) q_reg <= reg_d;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected write on reg_en and the expected ack on ack.
    always begin
        @(posedge clk or negedge rstn);
        if (!rstn) begin
            ack_q.delete();
            cnt_model = 8'h00;
        end else begin
            #1;
            check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
            check("ack_onehot", 32'($countones(ack) <= 1), 32'd1);
            if (reg_en) begin
                check("en_without_ack", 32'(ack), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(reg_en), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("write_gnt", 32'(gnt), 32'(1 << mon_e.idx));
                    check("write_data", 32'(reg_d), 32'(mon_e.data));
                    ack_q.push_back(mon_e);
                end
            end
            if (ack != 4'b0000) begin
                if (ack_q.size() == 0) begin
                    check("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    mon_e = ack_q.pop_front();
                    cnt_model = cnt_model + 8'd1;
                    check("ack_target", 32'(ack), 32'(1 << mon_e.idx));
                    check("ack_wr_count", 32'(wr_count), 32'(cnt_model));
                    check("ack_reg_q", 32'(q_reg), 32'(mon_e.data));
                end
            end
        end
    end

    // Requester behaviour: drop on ack (optionally delayed), optionally re-raise later.
    task automatic step();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (rr_cnt[i] > 0) begin
                rr_cnt[i]--;
                if (rr_cnt[i] == 0) req[i] = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (ack[i]) begin
                acks_seen++;
                ack_cyc.push_back(cyc);
                pend[i] = drop_delay[i];
            end
            if (pend[i] == 0) begin
                req[i]  = 1'b0;
                pend[i] = -1;
                if (reraise[i] > 0) rr_cnt[i] = reraise[i];
            end else if (pend[i] > 0) begin
                pend[i]--;
            end
        end
    endtask

    function automatic bit rr_idle();
        bit r = 1'b1;
        for (int i = 0; i < 4; i++) if (rr_cnt[i] != 0 || pend[i] >= 0) r = 1'b0;
        return r;
    endfunction

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(req == 4'b0000 && !busy && rr_idle()) && n < 200) begin
            step();
            n++;
        end
        check(name, {27'd0, req, busy}, 32'd0);
    endtask

    task automatic run_until_acks(input string name, input int target, input int max);
        int n = 0;
        while (acks_seen < target && n < max) begin
            step();
            n++;
        end
        check(name, 32'(acks_seen >= target), 32'd1);
    endtask

    task automatic push(input int idx, input logic [7:0] d);
        exp_t e;
        e.idx  = idx;
        e.data = d;
        exp_q.push_back(e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        acks_seen = 0;
        cyc       = 0;
        for (int i = 0; i < 4; i++) begin
            rr_cnt[i]     = 0;
            reraise[i]    = 0;
            pend[i]       = -1;
            drop_delay[i] = 0;
        end
        rstn    = 1'b0;
        req     = 4'b1111;
        data_in = 32'hD4C3B2A1;

        // 1: outputs quiet under reset even with all requests high.
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_en", 32'(reg_en), 32'd0);
        check("rst_d", 32'(reg_d), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(wr_count), 32'd0);
        push(0, 8'hA1);
        push(1, 8'hB2);
        push(2, 8'hC3);
        push(3, 8'hD4);
        rstn = 1'b1;
        wait_idle("t1_idle");

        // 2: single write; data changes after grant must not leak through.
        data_in[23:16] = 8'hA5;
        push(2, 8'hA5);
        req = 4'b0100;
        step();
        check("t2_en", 32'(reg_en), 32'd1);
        data_in[23:16] = 8'h5A;
        step();
        check("t2_ack", 32'(ack), 32'h4);
        check("t2_en_low", 32'(reg_en), 32'd0);
        check("t2_q", 32'(q_reg), 32'hA5);
        wait_idle("t2_idle");
        check("t2_count", 32'(wr_count), 32'd5);

        // 3: full contention from ptr=3; strict rotation, one write per 4 cycles.
        data_in = 32'h44332211;
        a0 = acks_seen;
        ack_cyc.delete();
        for (int i = 0; i < 4; i++) reraise[i] = 2;
        push(3, 8'h44); push(0, 8'h11); push(1, 8'h22); push(2, 8'h33);
        push(3, 8'h44); push(0, 8'h11); push(1, 8'h22); push(2, 8'h33);
        req = 4'b1111;
        run_until_acks("t3_first_round", a0 + 4, 100);
        for (int i = 0; i < 4; i++) reraise[i] = 0;
        wait_idle("t3_idle");
        check("t3_ack_total", 32'(ack_cyc.size()), 32'd8);
        for (int k = 1; k < ack_cyc.size(); k++) begin
            check("t3_period", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd4);
        end

        // 4: requester 0 re-raises right away; pending requester 2 goes first.
        a0 = acks_seen;
        reraise[0] = 2;
        push(0, 8'h11); push(2, 8'h33); push(0, 8'h11);
        req = 4'b0101;
        run_until_acks("t4_two_acks", a0 + 2, 100);
        reraise[0] = 0;
        wait_idle("t4_idle");
        check("t4_count", 32'(wr_count), 32'd16);

        // 5: reset pulse during LOAD abandons the write.
        push(3, 8'h44);
        req = 4'b1000;
        step();
        check("t5_in_load", 32'(reg_en), 32'd1);
        rstn = 1'b0;
        req  = 4'b0000;
        #1;
        check("t5_en", 32'(reg_en), 32'd0);
        check("t5_gnt", 32'(gnt), 32'd0);
        check("t5_ack", 32'(ack), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_count", 32'(wr_count), 32'd0);
        check("t5_q", 32'(q_reg), 32'd0);
        #2;
        rstn = 1'b1;
        repeat (4) step();
        check("t5_quiet", {27'd0, gnt, busy}, 32'd0);

        // 6: 256 writes from requester 1 wrap the counter, then a late release.
        a0 = acks_seen;
        reraise[1] = 2;
        for (int k = 0; k < 256; k++) push(1, 8'h22);
        req = 4'b0010;
        run_until_acks("t6_bulk", a0 + 255, 2000);
        reraise[1] = 0;
        wait_idle("t6_idle");
        check("t6_wrap", 32'(wr_count), 32'd0);

        a0 = acks_seen;
        drop_delay[1] = 5;
        push(1, 8'h22);
        req = 4'b0010;
        run_until_acks("t6_late_ack", a0 + 1, 20);
        for (int k = 0; k < 5; k++) begin
            step();
            check("t6_hold_gnt", 32'(gnt), 32'h2);
            check("t6_hold_busy", 32'(busy), 32'd1);
        end
        step();
        check("t6_released", {27'd0, gnt, busy}, 32'd0);
        check("t6_count", 32'(wr_count), 32'd1);

        check("sb_writes_left", 32'(exp_q.size()), 32'd0);
        check("sb_acks_left", 32'(ack_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
